// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: FSM encodings, word-offset constant and address-range helper
`default_nettype none
package mem_responder_pkg;

  localparam logic [1:0] MEM_IDLE = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] MEM_RESP = 2'd2;

  localparam int WORD_LSB = 2;

  // True when any byte-address bit above the word index is set.
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int addr_w);
    return |(addr >> (addr_w + WORD_LSB));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_word_array.sv
// mem_word_array: single-port RAM, synchronous write and combinational read of 32-bit words.
`default_nettype none
module mem_word_array #(
  parameter int ADDR_W    = 10,
  parameter int INIT_ZERO = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if (INIT_ZERO != 0) begin : g_zero_init
      // Declaration initialiser gives a zeroed array at time 0 without a reset network.
      logic [31:0] r_mem [DEPTH] = '{default: '0};
      always_ff @(posedge clk) begin
        if (we) r_mem[idx] <= wdata;
      end
      assign rdata = r_mem[idx];
    end else begin : g_no_init
      logic [31:0] r_mem [DEPTH];
      always_ff @(posedge clk) begin
        if (we) r_mem[idx] <= wdata;
      end
      assign rdata = r_mem[idx];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
// mem_responder: latency-programmable memory end of the cache miss/writeback interface.
// Optional MEM_RESP_ERR_EN adds mem_req_err for addresses beyond the array.
`default_nettype none
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int LATENCY   = 4,
  parameter int INIT_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_req_addr,
  input  logic        mem_req_valid,
  input  logic        mem_req_wr,
  input  logic [31:0] mem_wr_data,
`ifdef MEM_RESP_ERR_EN
  output logic        mem_req_err,
`endif
  output logic [31:0] mem_req_data,
  output logic        mem_req_ready
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_wr;
  logic [31:0]       r_wdata;
  logic              r_err;

  logic              w_addr_err;
  logic              w_commit;
  logic              w_we;
  logic [31:0]       w_rdata;

`ifdef MEM_RESP_ERR_EN
  logic [1:0] w_unused_addr;
  assign w_unused_addr = mem_req_addr[1:0];
  assign w_addr_err    = addr_out_of_range(mem_req_addr, ADDR_W);
  assign mem_req_err   = (r_state == MEM_RESP) && r_err;
`else
  // Upper bits alias; low bits are the byte offset within the word.
  logic [31-ADDR_W:0] w_unused_addr;
  assign w_unused_addr = {mem_req_addr[31:ADDR_W+WORD_LSB], mem_req_addr[1:0]};
  assign w_addr_err    = 1'b0;
`endif

  assign w_commit      = (r_state == MEM_WAIT) && (r_cnt == '0);
  assign w_we          = w_commit && r_wr && !r_err;
  assign mem_req_ready = (r_state == MEM_RESP);

  mem_word_array #(
    .ADDR_W    (ADDR_W),
    .INIT_ZERO (INIT_ZERO)
  ) u_array (
    .clk   (clk),
    .we    (w_we),
    .idx   (r_idx),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= MEM_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_wr         <= 1'b0;
      r_wdata      <= '0;
      r_err        <= 1'b0;
      mem_req_data <= '0;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (mem_req_valid) begin
            r_idx   <= mem_req_addr[ADDR_W+WORD_LSB-1:WORD_LSB];
            r_wr    <= mem_req_wr;
            r_wdata <= mem_wr_data;
            r_err   <= w_addr_err;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_state <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= MEM_RESP;
            if (!r_wr) mem_req_data <= r_err ? 32'h0 : w_rdata;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        MEM_RESP: r_state <= MEM_IDLE;
        default:  r_state <= MEM_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench driving a LATENCY=4 and a LATENCY=1 responder.
`default_nettype none
module tb_mem_responder;

  typedef struct {
    logic [31:0] data;
    int          lat;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstv  [2];
  logic [31:0] addr  [2];
  logic        valid [2];
  logic        wr    [2];
  logic [31:0] wd    [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        erro  [2];

  logic [31:0] mdl  [2][1024];
  logic [31:0] last [2];
  exp_t        sb [$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(10), .LATENCY(4), .INIT_ZERO(1)) dut_a (
    .clk           (clk),
    .rst           (rstv[0]),
    .mem_req_addr  (addr[0]),
    .mem_req_valid (valid[0]),
    .mem_req_wr    (wr[0]),
    .mem_wr_data   (wd[0]),
`ifdef MEM_RESP_ERR_EN
    .mem_req_err   (erro[0]),
`endif
    .mem_req_data  (rdata[0]),
    .mem_req_ready (ready[0])
  );

  mem_responder #(.ADDR_W(10), .LATENCY(1), .INIT_ZERO(1)) dut_b (
    .clk           (clk),
    .rst           (rstv[1]),
    .mem_req_addr  (addr[1]),
    .mem_req_valid (valid[1]),
    .mem_req_wr    (wr[1]),
    .mem_wr_data   (wd[1]),
`ifdef MEM_RESP_ERR_EN
    .mem_req_err   (erro[1]),
`endif
    .mem_req_data  (rdata[1]),
    .mem_req_ready (ready[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction: model updated and expectation queued at drive time,
  // popped and compared when the ready pulse is observed.
  task automatic xact(input int s, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input bit churn, input string tag);
    exp_t e;
    exp_t got;
    int   n;
    bit   seen;
    logic [9:0] idx;
    logic       aerr;
    idx  = a[11:2];
    aerr = 1'b0;
`ifdef MEM_RESP_ERR_EN
    aerr = |a[31:12];
`endif
    e.lat = (s == 0) ? 4 : 1;
    e.err = aerr;
    if (w) begin
      if (!aerr) mdl[s][idx] = d;
      e.data = last[s];
    end else begin
      e.data  = aerr ? 32'h0 : mdl[s][idx];
      last[s] = e.data;
    end
    sb.push_back(e);
    @(negedge clk);
    addr[s] = a; wr[s] = w; wd[s] = d; valid[s] = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (ready[s]) seen = 1'b1;
      else if (churn && n == 1) begin
        addr[s] = a ^ 32'h30; wr[s] = ~w; wd[s] = 32'hFFFF_FFFF;
      end
    end
    valid[s] = 1'b0;
    got = sb.pop_front();
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(n - 1), 32'(got.lat));
    chk({tag, "_data"}, rdata[s], got.data);
`ifdef MEM_RESP_ERR_EN
    chk({tag, "_err"}, 32'(erro[s]), 32'(got.err));
`endif
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(ready[s]), 32'd0);
  endtask

  initial begin
    int pulses;
    for (int s = 0; s < 2; s++) begin
      rstv[s] = 1'b0; addr[s] = '0; valid[s] = 1'b0; wr[s] = 1'b0; wd[s] = '0;
      last[s] = '0;
      for (int i = 0; i < 1024; i++) mdl[s][i] = '0;
    end

    // Reset held for three cycles, outputs quiet throughout.
    repeat (3) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        chk("rst_ready", 32'(ready[s]), 32'd0);
        chk("rst_data", rdata[s], 32'd0);
      end
    end
    rstv[0] = 1'b1; rstv[1] = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (ready[0] || ready[1]) pulses++;
    end
    chk("idle_no_ready", 32'(pulses), 32'd0);

    // Write then read-after-write, LATENCY=4.
    xact(0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, "wr40");
    xact(0, 1'b0, 32'h0000_0040, 32'h0, 1'b0, "rd40");

    // LATENCY=1 back-to-back reads, after seeding the words.
    xact(1, 1'b1, 32'h0000_0000, 32'h1111_0000, 1'b0, "b_wr0");
    xact(1, 1'b1, 32'h0000_0004, 32'h2222_0004, 1'b0, "b_wr4");
    xact(1, 1'b1, 32'h0000_0008, 32'h3333_0008, 1'b0, "b_wr8");
    xact(1, 1'b0, 32'h0000_0000, 32'h0, 1'b0, "b_rd0");
    xact(1, 1'b0, 32'h0000_0004, 32'h0, 1'b0, "b_rd4");
    xact(1, 1'b0, 32'h0000_0008, 32'h0, 1'b0, "b_rd8");

    // Input churn during WAIT must not redirect the read or create a write.
    xact(0, 1'b1, 32'h0000_0010, 32'hC0FF_EE10, 1'b0, "wr10");
    xact(0, 1'b0, 32'h0000_0010, 32'h0, 1'b1, "churn_rd10");
    xact(0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, "rd20");

    // Reset during WAIT of a write aborts it.
    xact(0, 1'b1, 32'h0000_0008, 32'h0BAD_CAFE, 1'b0, "wr8_old");
    @(negedge clk);
    addr[0] = 32'h8; wr[0] = 1'b1; wd[0] = 32'h1234_5678; valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rstv[0] = 1'b0;
    #1;
    chk("abort_ready_async", 32'(ready[0]), 32'd0);
    chk("abort_data_async", rdata[0], 32'd0);
    valid[0] = 1'b0;
    last[0]  = 32'h0;
    @(negedge clk);
    rstv[0] = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready[0]) pulses++;
    end
    chk("abort_no_ready", 32'(pulses), 32'd0);
    xact(0, 1'b0, 32'h0000_0008, 32'h0, 1'b0, "rd8_after_abort");

    // Address aliasing (or range error when the error output is built in).
    xact(0, 1'b1, 32'h0000_1004, 32'hA5A5_A5A5, 1'b0, "wr1004");
    xact(0, 1'b0, 32'h0000_0004, 32'h0, 1'b0, "rd4_alias");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
